// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default parameter values and small arithmetic helpers.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_REFILL   = 3'd2,
        ST_BPU_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } hz_state_e;

    localparam int DEF_FLUSH_DEPTH = 2;
    localparam int DEF_BPU_TIMEOUT = 15;
    localparam int DEF_CNT_W       = 16;
    localparam int REFILL_W        = 3;
    localparam int DWELL_W         = 8;

    function automatic logic [DWELL_W-1:0] sat_inc8(input logic [DWELL_W-1:0] val);
        if (val == {DWELL_W{1'b1}}) begin
            return val;
        end else begin
            return val + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates mispredict, load-use, predictor hold
// and debug halt into stall/flush/redirect controls with zero-cycle latency.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int BPU_TIMEOUT = DEF_BPU_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             mispredict,
    input  logic             bpu_stall,
    input  logic             halt_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             redirect,
    output logic [2:0]       state_o,
    output logic             bpu_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REFILL_W-1:0] REFILL_LOAD = REFILL_W'(FLUSH_DEPTH - 1);
    localparam logic [DWELL_W-1:0]  TIMEOUT_L   = DWELL_W'(BPU_TIMEOUT);

    hz_state_e           state_r;
    hz_state_e           state_nxt_s;
    logic [REFILL_W-1:0] refill_cnt_r;
    logic [REFILL_W-1:0] refill_nxt_s;
    logic [DWELL_W-1:0]  dwell_r;
    logic [DWELL_W-1:0]  dwell_nxt_s;
    logic [DWELL_W-1:0]  dwell_inc_s;
    logic                bpu_err_r;
    logic                bpu_err_nxt_s;
    logic                accept_mp_s;
    logic                stall_if_s;
    logic                stall_id_s;
    logic                flush_ex_s;

    // State, refill countdown, BPU dwell and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RUN;
            refill_cnt_r <= '0;
            dwell_r      <= '0;
            bpu_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            refill_cnt_r <= refill_nxt_s;
            dwell_r      <= dwell_nxt_s;
            bpu_err_r    <= bpu_err_nxt_s;
        end
    end

    // Next-state and output decode; mispredict outranks everything outside REFILL
    always_comb begin
        state_nxt_s  = state_r;
        refill_nxt_s = refill_cnt_r;
        accept_mp_s  = 1'b0;
        stall_if_s   = 1'b0;
        stall_id_s   = 1'b0;
        flush_ex_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mispredict) begin
                    accept_mp_s = 1'b1;
                end else if (load_use) begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    flush_ex_s  = 1'b1;
                    state_nxt_s = ST_LU_STALL;
                end else if (bpu_stall) begin
                    stall_if_s  = 1'b1;
                    state_nxt_s = ST_BPU_WAIT;
                end else if (halt_req) begin
                    stall_if_s  = 1'b1;
                    stall_id_s  = 1'b1;
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            // The stall already happened in RUN; this cycle only blocks re-triggering
            ST_LU_STALL: begin
                if (mispredict) begin
                    accept_mp_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_REFILL: begin
                if (refill_cnt_r == {REFILL_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    refill_nxt_s = refill_cnt_r - 3'd1;
                end
            end
            ST_BPU_WAIT: begin
                if (mispredict) begin
                    accept_mp_s = 1'b1;
                end else begin
                    stall_if_s  = (bpu_stall && !bpu_err_r) || load_use;
                    stall_id_s  = load_use;
                    flush_ex_s  = load_use;
                    state_nxt_s = (bpu_stall && !bpu_err_r) ? ST_BPU_WAIT : ST_RUN;
                end
            end
            ST_HALT: begin
                if (mispredict) begin
                    accept_mp_s = 1'b1;
                end else if (halt_req) begin
                    stall_if_s = 1'b1;
                    stall_id_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
        if (accept_mp_s) begin
            state_nxt_s  = ST_REFILL;
            refill_nxt_s = REFILL_LOAD;
        end else begin
            refill_nxt_s = refill_nxt_s;
        end
    end

    // Dwell counter runs only while parked in BPU_WAIT
    always_comb begin
        dwell_inc_s = sat_inc8(dwell_r);
        if (state_r == ST_BPU_WAIT) begin
            dwell_nxt_s   = dwell_inc_s;
            bpu_err_nxt_s = bpu_err_r | (dwell_inc_s == TIMEOUT_L);
        end else begin
            dwell_nxt_s   = '0;
            bpu_err_nxt_s = bpu_err_r;
        end
    end

    assign stall_if = rst && stall_if_s;
    assign stall_id = rst && stall_id_s;
    assign flush_if = rst && accept_mp_s;
    assign flush_id = rst && accept_mp_s;
    assign redirect = rst && accept_mp_s;
    assign flush_ex = rst && flush_ex_s;
    assign state_o  = state_r;
    assign bpu_err  = bpu_err_r;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_if_s),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept_mp_s),
        .count (flush_cnt)
    );

endmodule
